// File: rtl/rgb_uart_cmd.sv
// rgb_uart_cmd: parses "c<idx>\n" toggle and "c<idx>HH\n" set commands from the UART RX FIFO
// into per-channel RGB LED levels, with optional echo, '?' error reply and inter-character timeout.
module rgb_uart_cmd #(
  parameter int          NUM_LEDS       = 3,
  parameter logic [7:0]  TOGGLE_LEVEL   = 8'h11,
  parameter int          ECHO           = 1,
  parameter int          TIMEOUT_CYCLES = 8000000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Data_Ready,
  input  logic [7:0]            i_Data,
  output logic                  o_Read_Data,
  input  logic                  i_Busy_TX,
  output logic                  o_Start,
  output logic [7:0]            o_TX_Data,
  output logic [NUM_LEDS*24-1:0] o_Level,
  output logic                  o_Cmd_Done,
  output logic                  o_Cmd_Error
);
  localparam int NCH = NUM_LEDS * 3;
  localparam int CW  = $clog2(TIMEOUT_CYCLES);
  localparam bit EC  = ECHO != 0;

  typedef enum logic [2:0] {S_COLOUR, S_INDEX, S_HEXE, S_HEXLO, S_END, S_GAP, S_ERR} st_t;

  st_t                st_q, st_d, ret_q, ret_d;
  logic [1:0]         col_q, col_d;
  logic [3:0]         led_q, led_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NCH*8-1:0]   lvl_q, lvl_d;
  logic               done_q, done_d, err_q, err_d;
  logic               pop, tx_err, is_col, is_idx, is_dig, is_hex, wr, bad;
  logic [3:0]         hex_v;
  logic [4:0]         ch;
  logic [7:0]         cur, wv;

  assign is_col = i_Data == 8'h72 || i_Data == 8'h67 || i_Data == 8'h62;
  assign is_idx = i_Data >= 8'h31 && i_Data <= 8'(48 + NUM_LEDS);
  assign is_dig = i_Data >= 8'h30 && i_Data <= 8'h39;
  assign is_hex = is_dig || (i_Data >= 8'h61 && i_Data <= 8'h66) || (i_Data >= 8'h41 && i_Data <= 8'h46);
  assign hex_v  = is_dig ? i_Data[3:0] : i_Data[3:0] + 4'd9;
  assign ch     = 5'(led_q) * 5'd3 + 5'(col_q);

  // Strobes are decoded from the current state so a byte is consumed the cycle it is seen.
  assign pop    = i_Reset_n && st_q != S_GAP && st_q != S_ERR && i_Data_Ready && (!i_Busy_TX || !EC);
  assign tx_err = st_q == S_ERR && !i_Busy_TX;

  assign o_Read_Data = pop;
  assign o_Start     = (pop && EC) || tx_err;
  assign o_TX_Data   = (pop && EC) ? i_Data : tx_err ? 8'h3F : 8'h00;
  assign o_Level     = lvl_q;
  assign o_Cmd_Done  = done_q;
  assign o_Cmd_Error = err_q;

  always_comb begin
    cur = 8'h00;
    for (int k = 0; k < NCH; k++) if (ch == 5'(k)) cur = lvl_q[8*k +: 8];
    st_d   = st_q;
    ret_d  = ret_q;
    col_d  = col_q;
    led_d  = led_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = '0;
    done_d = 1'b0;
    err_d  = 1'b0;
    wr     = 1'b0;
    wv     = 8'h00;
    bad    = 1'b0;
    if (st_q == S_GAP) st_d = ret_q;
    else if (st_q == S_ERR) begin
      if (!i_Busy_TX) begin
        st_d  = S_GAP;
        ret_d = S_COLOUR;
      end
    end else if (pop) begin
      st_d  = S_GAP;
      ret_d = st_q;
      if (i_Data != 8'h0D)
        case (st_q)
          S_COLOUR: if (is_col) begin
            col_d = i_Data == 8'h72 ? 2'd0 : i_Data == 8'h67 ? 2'd1 : 2'd2;
            ret_d = S_INDEX;
          end
          S_INDEX: if (is_idx) begin
            led_d = i_Data[3:0] - 4'd1;
            ret_d = S_HEXE;
          end else bad = 1'b1;
          S_HEXE: if (i_Data == 8'h0A) begin
            wr = 1'b1;
            wv = cur == 8'h00 ? TOGGLE_LEVEL : 8'h00;
          end else if (is_hex) begin
            hi_d  = hex_v;
            ret_d = S_HEXLO;
          end else bad = 1'b1;
          S_HEXLO: if (is_hex) begin
            lo_d  = hex_v;
            ret_d = S_END;
          end else bad = 1'b1;
          default: if (i_Data == 8'h0A) begin
            wr = 1'b1;
            wv = {hi_q, lo_q};
          end else bad = 1'b1;
        endcase
      if (wr) begin
        done_d = 1'b1;
        ret_d  = S_COLOUR;
      end
      if (bad) begin
        err_d = 1'b1;
        ret_d = EC ? S_ERR : S_COLOUR;
      end
    end else if (st_q != S_COLOUR) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        st_d  = S_COLOUR;
        cnt_d = '0;
        err_d = 1'b1;
      end
    end
    lvl_d = lvl_q;
    for (int k = 0; k < NCH; k++) if (wr && ch == 5'(k)) lvl_d[8*k +: 8] = wv;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      st_q   <= S_COLOUR;
      ret_q  <= S_COLOUR;
      col_q  <= 2'd0;
      led_q  <= 4'd0;
      hi_q   <= 4'd0;
      lo_q   <= 4'd0;
      cnt_q  <= '0;
      lvl_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      ret_q  <= ret_d;
      col_q  <= col_d;
      led_q  <= led_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
endmodule

// File: tb/tb_rgb_uart_cmd.sv
// tb_rgb_uart_cmd: FIFO/transmitter model around rgb_uart_cmd with an echo and command-event scoreboard,
// plus a second silent (no echo) instance fed with the transmitter permanently busy.
module tb_rgb_uart_cmd;
  localparam int LW = 72;

  typedef struct {
    logic [1:0]    kind;
    logic [LW-1:0] lvl;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rdy, rd, busy, start, done, err;
  logic [7:0]    dat, txd;
  logic [LW-1:0] lvl;
  logic          rdy0, rd0, start0, done0, err0;
  logic [7:0]    dat0, txd0;
  logic [LW-1:0] lvl0;

  byte           rxq[$], rxq0[$], exp_tx[$];
  ev_t           exp_ev[$];
  logic [LW-1:0] model;
  logic          force_busy;
  int            n_vec, n_err, ndone, nstart0, ndone0, nerr0, bcnt;
  logic          prev_rd, prev_st;

  rgb_uart_cmd #(.NUM_LEDS(3), .TOGGLE_LEVEL(8'h11), .ECHO(1), .TIMEOUT_CYCLES(40)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Data_Ready(rdy), .i_Data(dat), .o_Read_Data(rd),
    .i_Busy_TX(busy), .o_Start(start), .o_TX_Data(txd), .o_Level(lvl),
    .o_Cmd_Done(done), .o_Cmd_Error(err));

  rgb_uart_cmd #(.NUM_LEDS(3), .TOGGLE_LEVEL(8'h11), .ECHO(0), .TIMEOUT_CYCLES(40)) dut0 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Data_Ready(rdy0), .i_Data(dat0), .o_Read_Data(rd0),
    .i_Busy_TX(1'b1), .o_Start(start0), .o_TX_Data(txd0), .o_Level(lvl0),
    .o_Cmd_Done(done0), .o_Cmd_Error(err0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input byte b);
    rxq.push_back(b);
    exp_tx.push_back(b);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push_byte(s[i]);
  endtask

  task automatic add_ev(input logic [1:0] kind);
    ev_t e;
    e.kind = kind;
    e.lvl  = model;
    exp_ev.push_back(e);
  endtask

  task automatic commit(input int c, input logic [7:0] v);
    model[8*c +: 8] = v;
    add_ev(2'b10);
  endtask

  task automatic tog(input int c);
    commit(c, model[8*c +: 8] == 8'h00 ? 8'h11 : 8'h00);
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (rxq.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, n < 2000, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((rxq.size() != 0 || exp_tx.size() != 0 || exp_ev.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, n < 2000, 1);
    repeat (4) @(posedge clk);
  endtask

  // Monitor samples mid-cycle; FIFO pops and transmitter busy advance just after the active edge.
  initial begin
    logic pr, pr0, ps;
    ev_t  e;
    prev_rd = 1'b0;
    prev_st = 1'b0;
    bcnt    = 0;
    forever begin
      @(negedge clk);
      if (rd) chk("rd_b2b", prev_rd, 0);
      if (start) begin
        chk("start_b2b", prev_st, 0);
        chk("start_busy", busy, 0);
        chk("tx_pending", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) chk("tx_byte", txd, exp_tx.pop_front());
      end
      if (done) ndone++;
      if (done || err) begin
        chk("ev_pending", exp_ev.size() != 0, 1);
        if (exp_ev.size() != 0) begin
          e = exp_ev.pop_front();
          chk("ev_kind", {done, err}, e.kind);
          chk("ev_level", lvl, e.lvl);
        end
      end
      if (start0) nstart0++;
      if (done0) ndone0++;
      if (err0) nerr0++;
      prev_rd = rd;
      prev_st = start;
      pr  = rd;
      pr0 = rd0;
      ps  = start;
      @(posedge clk);
      #1;
      if (pr && rxq.size() != 0) void'(rxq.pop_front());
      if (pr0 && rxq0.size() != 0) void'(rxq0.pop_front());
      if (ps) bcnt = 3;
      else if (bcnt > 0) bcnt--;
      busy = force_busy || bcnt > 0;
      rdy  = rxq.size() != 0;
      dat  = rxq.size() != 0 ? rxq[0] : 8'h00;
      rdy0 = rxq0.size() != 0;
      dat0 = rxq0.size() != 0 ? rxq0[0] : 8'h00;
    end
  end

  initial begin
    string s0;
    n_vec = 0; n_err = 0; ndone = 0; nstart0 = 0; ndone0 = 0; nerr0 = 0;
    rst_n = 1'b0; force_busy = 1'b0; model = '0;
    rdy = 1'b0; dat = 8'h00; busy = 1'b0; rdy0 = 1'b0; dat0 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", lvl, 0);
    chk("rst_rd", rd, 0);
    chk("rst_start", start, 0);
    chk("rst_done", {done, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = "g1c3\n";
    for (int i = 0; i < s0.len(); i++) rxq0.push_back(s0[i]);

    push_str("r1\n"); tog(0);
    push_str("r1\n"); tog(0);
    wait_idle("t1_wait");
    chk("t1_r1", lvl[7:0], 8'h00);
    chk("t1_done", ndone, 2);

    push_str("g3A5\n"); commit(7, 8'hA5);
    push_str("b2ff"); push_byte(8'h0D); push_str("\n"); commit(5, 8'hFF);
    wait_idle("t2_wait");
    chk("t2_g3", lvl[63:56], 8'hA5);
    chk("t2_b2", lvl[47:40], 8'hFF);
    chk("t2_all", lvl, model);

    push_str("rx"); exp_tx.push_back(8'h3F); add_ev(2'b01);
    push_str("1\n");
    wait_idle("t3_wait");
    chk("t3_lvl", lvl, model);

    push_str("r4"); exp_tx.push_back(8'h3F); add_ev(2'b01);
    push_str("\n");
    wait_idle("t4_wait");
    push_str("r15"); add_ev(2'b01);
    wait_rx("t4_rx");
    repeat (30) @(posedge clk);
    chk("to_early", exp_ev.size(), 1);
    wait_idle("to_wait");
    chk("to_lvl", lvl, model);
    push_str("r1\n"); tog(0);
    wait_idle("t4b_wait");
    chk("t4_r1", lvl[7:0], 8'h11);

    force_busy = 1'b1;
    repeat (2) @(posedge clk);
    push_str("b310\n"); commit(8, 8'h10);
    repeat (20) @(posedge clk);
    chk("busy_hold", rxq.size(), 5);
    force_busy = 1'b0;
    wait_idle("t5_wait");
    chk("t5_b3", lvl[71:64], 8'h10);

    chk("e0_rx", rxq0.size(), 0);
    chk("e0_lvl", lvl0, 72'hC3 << 8);
    chk("e0_start", nstart0, 0);
    chk("e0_done", ndone0, 1);
    chk("e0_err", nerr0, 0);

    push_str("b1");
    wait_idle("t6_wait");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_level", lvl, 0);
    chk("arst_rd", rd, 0);
    model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    push_str("80\n");
    wait_idle("t6b_wait");
    repeat (10) @(posedge clk);
    chk("post_rst_lvl", lvl, 0);
    chk("ev_left", exp_ev.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
